// File: rtl/dcache_controller_pkg.sv
// -----------------------------------------------------------------------------
// dcache_controller_pkg
// Shared parameters, state encoding and address-field helpers for the
// direct-mapped, write-back, write-allocate data cache.
//   - Geometry: 8-bit words, 8-bit byte address, 8 lines of 4 words.
//   - Address split: {tag[7:5], index[4:2], offset[1:0]}.
//   - Memory side moves whole 32-bit blocks addressed by {tag, index}.
// -----------------------------------------------------------------------------
package dcache_controller_pkg;

    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 8;
    localparam int NUM_SETS    = 8;
    localparam int BLOCK_WORDS = 4;

    localparam int IDX_W      = $clog2(NUM_SETS);
    localparam int OFF_W      = $clog2(BLOCK_WORDS);
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W;
    localparam int MEM_ADDR_W = ADDR_W - OFF_W;
    localparam int BLOCK_W    = DATA_W * BLOCK_WORDS;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        MEM_READ   = 2'd2
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] index;
        logic [OFF_W-1:0] offset;
    } addr_fields_t;

    // Word 0 lives in the least significant byte of a block.
    function automatic logic [DATA_W-1:0] select_word(
        input logic [BLOCK_W-1:0] line,
        input logic [OFF_W-1:0]   offset
    );
        return line[offset*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/dcache_controller_array.sv
// -----------------------------------------------------------------------------
// dcache_controller_array
// Tag / valid / dirty / data storage for the data cache.
//   CLOCK, RESET          : clock, synchronous active-high reset
//   index                 : line selected for read, word write and fill
//   word_we, word_offset,
//   word_data             : CPU store into one word of the line (marks dirty)
//   fill_we, fill_tag,
//   fill_data             : whole-line refill from memory (valid, clean)
//   line_valid, line_dirty,
//   line_tag, line_data   : combinational view of the selected line
// RESET invalidates every line; tag and data contents are left untouched.
// -----------------------------------------------------------------------------
module dcache_controller_array
    import dcache_controller_pkg::*;
(
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [IDX_W-1:0]   index,
    input  logic               word_we,
    input  logic [OFF_W-1:0]   word_offset,
    input  logic [DATA_W-1:0]  word_data,
    input  logic               fill_we,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [BLOCK_W-1:0] fill_data,
    output logic               line_valid,
    output logic               line_dirty,
    output logic [TAG_W-1:0]   line_tag,
    output logic [BLOCK_W-1:0] line_data
);

    logic [NUM_SETS-1:0] valid;
    logic [NUM_SETS-1:0] dirty;
    logic [TAG_W-1:0]    tags  [NUM_SETS];
    logic [BLOCK_W-1:0]  data  [NUM_SETS];

    // Status bits: the only state that must be known after reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill_we) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (word_we) begin
            dirty[index] <= 1'b1;
        end
    end

    // NOTE: storage arrays carry no reset; an invalid line's contents are never
    // observed, and leaving them unreset lets them map onto plain RAM.
    always_ff @(posedge CLOCK) begin
        if (fill_we) begin
            tags[index] <= fill_tag;
            data[index] <= fill_data;
        end else if (word_we) begin
            data[index][word_offset*DATA_W +: DATA_W] <= word_data;
        end
    end

    assign line_valid = valid[index];
    assign line_dirty = dirty[index];
    assign line_tag   = tags[index];
    assign line_data  = data[index];

endmodule

// File: rtl/dcache_controller.sv
// -----------------------------------------------------------------------------
// dcache_controller
// Direct-mapped, write-back, write-allocate data cache between the CPU and a
// slow block-wide data memory.
//   CLOCK, RESET       : clock, synchronous active-high reset
//   read, write        : CPU load / store request, held until busywait is low
//   address, writedata : CPU byte address and store data
//   readdata           : load data, valid while read=1 and busywait=0
//   busywait           : CPU stall
//   mem_read/mem_write : block read / write request to memory
//   mem_address        : block address {tag, index}
//   mem_writedata      : victim block (word 0 in [7:0])
//   mem_readdata       : fetched block (word 0 in [7:0])
//   mem_busywait       : memory busy; a request is complete when it drops
// Hits are served with zero stall; a miss optionally writes back the dirty
// victim, then refills the line and returns to IDLE where the request hits.
// -----------------------------------------------------------------------------
module dcache_controller
    import dcache_controller_pkg::*;
(
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic                  busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]    mem_writedata,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait
);

    state_t       state;
    logic         issued;   // set after the first cycle of a memory state
    addr_fields_t fields;

    logic               line_valid;
    logic               line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;

    logic hit;
    logic request;
    logic word_we;
    logic fill_we;

    assign fields  = addr_fields_t'(address);
    assign request = read | write;
    assign hit     = line_valid && (line_tag == fields.tag);

    // A store commits only once the line is resident; read&write acts as a store.
    assign word_we = !RESET && (state == IDLE) && write && hit;
    assign fill_we = !RESET && (state == MEM_READ) && issued && !mem_busywait;

    dcache_controller_array u_array (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .index       (fields.index),
        .word_we     (word_we),
        .word_offset (fields.offset),
        .word_data   (writedata),
        .fill_we     (fill_we),
        .fill_tag    (fields.tag),
        .fill_data   (mem_readdata),
        .line_valid  (line_valid),
        .line_dirty  (line_dirty),
        .line_tag    (line_tag),
        .line_data   (line_data)
    );

    // The memory's busywait may still show the previous (idle) value in the
    // first cycle of a request, so it is only trusted once issued is set.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state  <= IDLE;
            issued <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    issued <= 1'b0;
                    if (request && !hit)
                        state <= (line_valid && line_dirty) ? WRITE_BACK : MEM_READ;
                end
                WRITE_BACK: begin
                    if (!issued) begin
                        issued <= 1'b1;
                    end else if (!mem_busywait) begin
                        issued <= 1'b0;
                        state  <= MEM_READ;
                    end
                end
                MEM_READ: begin
                    if (!issued) begin
                        issued <= 1'b1;
                    end else if (!mem_busywait) begin
                        issued <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    issued <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode from the state; RESET masks everything so an aborted
    // miss drops its memory request in the reset cycle itself.
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        busywait      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        readdata      = '0;
        if (!RESET) begin
            readdata = select_word(line_data, fields.offset);
            case (state)
                IDLE: begin
                    busywait = request && !hit;
                end
                WRITE_BACK: begin
                    busywait      = 1'b1;
                    mem_write     = 1'b1;
                    mem_address   = {line_tag, fields.index};
                    mem_writedata = line_data;
                end
                MEM_READ: begin
                    busywait    = 1'b1;
                    mem_read    = 1'b1;
                    mem_address = {fields.tag, fields.index};
                end
                default: begin
                    busywait = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// -----------------------------------------------------------------------------
// tb_dcache_controller
// Self-checking bench: a behavioural block memory with programmable latency,
// a flat byte-array reference of what the CPU should see, and a queue of
// expected load results popped when each load completes.
// -----------------------------------------------------------------------------
module tb_dcache_controller;
    import dcache_controller_pkg::*;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        read  = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  address   = '0;
    logic [7:0]  writedata = '0;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait = 1'b0;

    always #5 CLOCK = ~CLOCK;

    dcache_controller dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    // ---------------- memory model ----------------
    function automatic logic [31:0] init_word(input int i);
        logic [31:0] w;
        if (i == 0) return 32'h44332211;
        if (i == 8) return 32'hDDCCBBAA;
        for (int b = 0; b < 4; b++)
            w[8*b +: 8] = 8'((4*i + b) ^ 8'hA5);
        return w;
    endfunction

    logic [31:0] mem_model [64];
    logic [7:0]  prev_req  = '0;
    int          mem_cnt   = 0;
    int          mem_lat   = 0;
    logic        mem_init_done = 1'b0;

    assign mem_readdata = mem_model[mem_address];

    // Busy during cycles 2..lat+1 of each request, done from cycle lat+2 on.
    always @(posedge CLOCK) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) mem_model[i] <= init_word(i);
            mem_init_done <= 1'b1;
        end else if (mem_read || mem_write) begin
            if ({mem_read, mem_write, mem_address} != prev_req) begin
                mem_cnt      <= 1;
                mem_busywait <= (mem_lat >= 1);
                if (mem_write) mem_model[mem_address] <= mem_writedata;
            end else begin
                mem_cnt      <= mem_cnt + 1;
                mem_busywait <= (mem_cnt + 1 <= mem_lat);
            end
        end else begin
            mem_cnt      <= 0;
            mem_busywait <= 1'b0;
        end
        prev_req <= {mem_read, mem_write, mem_address};
    end

    // ---------------- reference + scoreboard ----------------
    logic [7:0] ref_bytes [256];
    logic [7:0] exp_q [$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } snap_t;
    snap_t trace [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // op: 0 = load, 1 = store, 2 = load+store (acts as store)
    task automatic run_op(input int op, input logic [7:0] a, input logic [7:0] wd,
                          output int stall);
        int n;
        logic [7:0] exp;
        @(negedge CLOCK);
        read      = (op != 1);
        write     = (op != 0);
        address   = a;
        writedata = wd;
        if (op == 0) exp_q.push_back(ref_bytes[a]);
        #1;
        trace.delete();
        n = 0;
        forever begin
            trace.push_back('{mem_read, mem_write, mem_address, mem_writedata});
            if (!busywait) break;
            if (n >= 200) begin
                check("op_timeout", 32'(n), 32'd0);
                break;
            end
            @(negedge CLOCK);
            #1;
            n++;
        end
        if (op == 0 && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check($sformatf("readdata[%02h]", a), 32'(readdata), 32'(exp));
        end
        if (op != 0) ref_bytes[a] = wd;
        stall = n;
        @(negedge CLOCK);
        read  = 1'b0;
        write = 1'b0;
    endtask

    typedef struct {
        int         op;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         exp_stall;
    } vec_t;
    vec_t vecs [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st;
        for (int a = 0; a < 256; a++) begin
            logic [31:0] w;
            w = init_word(a / 4);
            ref_bytes[a] = w[8*(a % 4) +: 8];
        end

        // ---- reset behaviour: outputs forced low even with a request ----
        @(negedge CLOCK);
        @(negedge CLOCK);
        read = 1'b1; address = 8'h00;
        #1;
        check("rst_busywait",  32'(busywait),  32'd0);
        check("rst_mem_read",  32'(mem_read),  32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_readdata",  32'(readdata),  32'd0);
        @(negedge CLOCK);
        read = 1'b0; RESET = 1'b0;
        #1;
        check("rst_valid_all", 32'(dut.u_array.valid), 32'd0);
        check("rst_dirty_all", 32'(dut.u_array.dirty), 32'd0);

        // ---- clean miss, memory never busy: 1 IDLE + 2 MEM_READ cycles ----
        mem_lat = 0;
        run_op(0, 8'h00, 8'h00, st);
        check("miss0_stall",      32'(st), 32'd3);
        check("miss0_idle_nomem", 32'(trace[0].rd), 32'd0);
        check("miss0_mem_read",   32'(trace[1].rd), 32'd1);
        check("miss0_mem_addr",   32'(trace[1].addr), 32'h00);
        check("miss0_mem_read2",  32'(trace[2].rd), 32'd1);
        check("miss0_valid0",     32'(dut.u_array.valid[0]), 32'd1);

        // ---- read hit, same cycle ----
        run_op(0, 8'h02, 8'h00, st);
        check("hit02_stall",    32'(st), 32'd0);
        check("hit02_no_mread", 32'(trace[0].rd), 32'd0);

        // ---- write hit, then read it back ----
        run_op(1, 8'h01, 8'hAA, st);
        check("wr01_stall",  32'(st), 32'd0);
        check("wr01_dirty0", 32'(dut.u_array.dirty[0]), 32'd1);
        run_op(0, 8'h01, 8'h00, st);
        check("rd01_stall", 32'(st), 32'd0);

        // ---- conflict miss on dirty line: write-back then refill ----
        run_op(0, 8'h20, 8'h00, st);
        check("wb_stall",      32'(st), 32'd5);
        check("wb_mem_write",  32'(trace[1].wr), 32'd1);
        check("wb_no_read",    32'(trace[1].rd), 32'd0);
        check("wb_mem_addr",   32'(trace[1].addr), 32'h00);
        check("wb_mem_wdata",  trace[1].wdata, 32'h4433AA11);
        check("wb_write2",     32'(trace[2].wr), 32'd1);
        check("wb_fill_read",  32'(trace[3].rd), 32'd1);
        check("wb_fill_addr",  32'(trace[3].addr), 32'h08);
        check("wb_fill_read2", 32'(trace[4].rd), 32'd1);
        check("wb_dirty0",     32'(dut.u_array.dirty[0]), 32'd0);
        check("wb_mem_stored", mem_model[0], 32'h4433AA11);

        // ---- reset in the middle of a refill ----
        mem_lat = 3;
        @(negedge CLOCK);
        read = 1'b1; address = 8'h00;
        @(negedge CLOCK);
        #1;
        check("abort_mem_read_before", 32'(mem_read), 32'd1);
        @(negedge CLOCK);
        RESET = 1'b1;
        #1;
        check("abort_mem_read",  32'(mem_read), 32'd0);
        check("abort_busywait",  32'(busywait), 32'd0);
        check("abort_readdata",  32'(readdata), 32'd0);
        @(negedge CLOCK);
        RESET = 1'b0; read = 1'b0;
        #1;
        check("abort_state_idle", 32'(dut.state), 32'(IDLE));
        check("abort_valid0",     32'(dut.u_array.valid[0]), 32'd0);
        run_op(0, 8'h20, 8'h00, st);
        check("reread20_stall", 32'(st), 32'd6);
        run_op(0, 8'h00, 8'h00, st);
        check("reread00_stall", 32'(st), 32'd6);

        // ---- table-driven sequence, memory latency 1 ----
        vecs[0]  = '{0, 8'h04, 8'h00, 4};
        vecs[1]  = '{0, 8'h07, 8'h00, 0};
        vecs[2]  = '{1, 8'h05, 8'h5A, 0};
        vecs[3]  = '{0, 8'h05, 8'h00, 0};
        vecs[4]  = '{1, 8'h48, 8'h77, 4};
        vecs[5]  = '{0, 8'h48, 8'h00, 0};
        vecs[6]  = '{0, 8'h24, 8'h00, 7};
        vecs[7]  = '{0, 8'h05, 8'h00, 4};
        vecs[8]  = '{1, 8'hFF, 8'hC3, 4};
        vecs[9]  = '{0, 8'hFC, 8'h00, 0};
        vecs[10] = '{0, 8'hE8, 8'h00, 7};
        vecs[11] = '{0, 8'h4B, 8'h00, 4};
        vecs[12] = '{2, 8'h4A, 8'h99, 0};
        vecs[13] = '{0, 8'h4A, 8'h00, 0};
        vecs[14] = '{0, 8'h48, 8'h00, 0};
        vecs[15] = '{0, 8'hFF, 8'h00, 0};

        mem_lat = 1;
        @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, st);
            check($sformatf("vec%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
        end

        // ---- quiescent memory interface in IDLE ----
        #1;
        check("idle_mem_addr",  32'(mem_address), 32'd0);
        check("idle_mem_wdata", mem_writedata, 32'd0);
        check("idle_mem_req",   32'({mem_read, mem_write}), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
